kbd_lcd_stream_writer: RTL and testbench



---
 rtl/kbd_lcd_pkg.sv | 34 +++
 rtl/kbd_byte_fifo.sv | 51 +++++
 rtl/kbd_lcd_stream_writer.sv | 158 +++++++++++++++
 tb/tb_kbd_lcd_stream_writer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_lcd_pkg.sv
// Shared types and constants for the keyboard-to-LCD character stream writer.
package kbd_lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDStart,
    StDWait,
    StCStart,
    StCWait,
    StDone
  } lcd_state_e;

  localparam int unsigned FrmStart   = 10;
  localparam int unsigned FrmDataMsb = 9;
  localparam int unsigned FrmDataLsb = 2;
  localparam int unsigned FrmParity  = 1;
  localparam int unsigned FrmStop    = 0;

  localparam logic [7:0] LcdSetAddr = 8'h80;
  localparam logic [7:0] BreakCode  = 8'hF0;

  // Element i is the DDRAM base address of LCD line i.
  localparam logic [3:0][7:0] LineBase = {8'h54, 8'h14, 8'h40, 8'h00};

  // PS/2 sends the LSB first, so it lands in the highest data bit of the frame.
  function automatic logic [7:0] frame_byte(input logic [10:0] frame);
    return {frame[2], frame[3], frame[4], frame[5], frame[6], frame[7], frame[8], frame[9]};
  endfunction

  function automatic logic frame_ok(input logic [10:0] frame);
    return !frame[FrmStart] && frame[FrmStop] && (^frame[FrmDataMsb:FrmParity]);
  endfunction

endpackage

// File: rtl/kbd_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; a push on a full FIFO succeeds only with a pop.
module kbd_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AddrW + 1)'(DEPTH));
  assign w_rd    = i_pop && (r_count != '0);
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/kbd_lcd_stream_writer.sv
// Streams PS/2 keyboard bytes to an HD44780-style LCD writer, wrapping lines with
// set-address commands.
module kbd_lcd_stream_writer
  import kbd_lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LINE_LEN     = 16,
  parameter int unsigned NUM_LINES    = 2,
  parameter bit          FILTER_BREAK = 1'b1
) (
  input  logic                        sm_clk,
  input  logic                        reset,
  input  logic [10:0]                 kbd_data,
  input  logic                        kbd_ready,
  output logic                        reset_kbd_data,
  output logic                        start_LCD_writer,
  input  logic                        LCD_writer_finished,
  output logic [7:0]                  DB,
  output logic                        is_command,
  output logic                        finish,
  output logic                        parity_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned ColW = $clog2(LINE_LEN + 1);

  lcd_state_e      r_state;
  lcd_state_e      w_state_d;
  logic            r_ready_q;
  logic            r_cap_vld;
  logic [10:0]     r_frame;
  logic            r_skip;
  logic            r_perr;
  logic            r_ovf;
  logic [7:0]      r_db;
  logic [ColW-1:0] r_col;
  logic [1:0]      r_line;

  logic            w_frame_ok;
  logic [7:0]      w_byte;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic [7:0]      w_head;
  logic [ColW-1:0] w_col_inc;
  logic            w_eol;
  logic [1:0]      w_line_next;

  assign w_frame_ok  = frame_ok(r_frame);
  assign w_byte      = frame_byte(r_frame);
  assign w_push      = r_cap_vld && w_frame_ok &&
                       (!FILTER_BREAK || ((w_byte != BreakCode) && !r_skip));
  assign w_pop       = (r_state == StIdle) && (fifo_count != '0);
  assign w_col_inc   = r_col + 1'b1;
  assign w_eol       = (w_col_inc == ColW'(LINE_LEN));
  assign w_line_next = (r_line == 2'(NUM_LINES - 1)) ? 2'd0 : r_line + 2'd1;

  assign reset_kbd_data = r_cap_vld;
  assign parity_err     = r_perr;
  assign overflow       = r_ovf;
  assign DB             = r_db;

  // Edge detector is primed from the live level during reset so a held kbd_ready
  // does not look like a fresh frame once reset releases.
  always_ff @(posedge sm_clk) begin
    if (!reset) begin
      r_ready_q <= kbd_ready;
      r_cap_vld <= 1'b0;
      r_frame   <= '0;
      r_skip    <= 1'b0;
      r_perr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ready_q <= kbd_ready;
      r_cap_vld <= kbd_ready && !r_ready_q;
      if (kbd_ready && !r_ready_q) r_frame <= kbd_data;
      if (r_cap_vld) begin
        if (!w_frame_ok) begin
          r_perr <= 1'b1;
        end else if (FILTER_BREAK) begin
          if (w_byte == BreakCode) r_skip <= 1'b1;
          else if (r_skip)         r_skip <= 1'b0;
        end
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  kbd_byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .i_clk   (sm_clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (w_byte),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

  always_ff @(posedge sm_clk) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_pop) w_state_d = StDStart;
      StDStart: w_state_d = StDWait;
      StDWait:  if (LCD_writer_finished) w_state_d = w_eol ? StCStart : StDone;
      StCStart: w_state_d = StCWait;
      StCWait:  if (LCD_writer_finished) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    start_LCD_writer = 1'b0;
    is_command       = 1'b0;
    finish           = 1'b0;
    unique case (r_state)
      StDStart: start_LCD_writer = 1'b1;
      StCStart: begin
        start_LCD_writer = 1'b1;
        is_command       = 1'b1;
      end
      StCWait:  is_command = 1'b1;
      StDone:   finish = 1'b1;
      default:  ;
    endcase
  end

  // The line-wrap command is loaded into DB as the last character completes so it is
  // already stable when C_START raises the request.
  always_ff @(posedge sm_clk) begin
    if (!reset) begin
      r_db   <= 8'h00;
      r_col  <= '0;
      r_line <= 2'd0;
    end else begin
      if (w_pop) r_db <= w_head;
      if ((r_state == StDWait) && LCD_writer_finished) begin
        r_col <= w_col_inc;
        if (w_eol) r_db <= LcdSetAddr | LineBase[w_line_next];
      end
      if (r_state == StCStart) begin
        r_col  <= '0;
        r_line <= w_line_next;
      end
    end
  end

endmodule

// File: tb/tb_kbd_lcd_stream_writer.sv
// Self-checking bench: transaction-level model of the character stream plus directed cases.
module tb_kbd_lcd_stream_writer;

  localparam int unsigned FD = 4;
  localparam int unsigned LL = 16;
  localparam int unsigned NL = 2;

  logic        sm_clk    = 1'b0;
  logic        reset     = 1'b0;
  logic [10:0] kbd_data  = '0;
  logic        kbd_ready = 1'b0;
  logic        resp_fin  = 1'b0;
  logic        spur_fin  = 1'b0;
  logic        lcd_fin;
  logic        fin_nf    = 1'b0;

  logic       reset_kbd_data, start_lcd, is_command, finish, parity_err, overflow;
  logic [7:0] db;
  logic [2:0] fifo_count;
  logic       rkd_nf, start_nf, cmd_nf, finish_nf, perr_nf, ovf_nf;
  logic [7:0] db_nf;
  logic [2:0] cnt_nf;

  assign lcd_fin = resp_fin | spur_fin;

  kbd_lcd_stream_writer #(
    .FIFO_DEPTH(FD), .LINE_LEN(LL), .NUM_LINES(NL), .FILTER_BREAK(1'b1)
  ) dut (
    .sm_clk(sm_clk), .reset(reset), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .reset_kbd_data(reset_kbd_data), .start_LCD_writer(start_lcd),
    .LCD_writer_finished(lcd_fin), .DB(db), .is_command(is_command), .finish(finish),
    .parity_err(parity_err), .overflow(overflow), .fifo_count(fifo_count)
  );

  kbd_lcd_stream_writer #(
    .FIFO_DEPTH(FD), .LINE_LEN(LL), .NUM_LINES(NL), .FILTER_BREAK(1'b0)
  ) dut_nf (
    .sm_clk(sm_clk), .reset(reset), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .reset_kbd_data(rkd_nf), .start_LCD_writer(start_nf),
    .LCD_writer_finished(fin_nf), .DB(db_nf), .is_command(cmd_nf), .finish(finish_nf),
    .parity_err(perr_nf), .overflow(ovf_nf), .fifo_count(cnt_nf)
  );

  initial forever #5 sm_clk = ~sm_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model of the expected character stream.
  logic [7:0] m_q[$];
  int         m_col = 0;
  int         m_line = 0;
  bit         m_need_cmd = 0, m_perr = 0, m_ovf = 0, m_skip = 0;
  bit         outst = 0, cur_cmd = 0, fin_due = 0;
  logic [7:0] cur_db;
  logic       cur_isc;
  logic [7:0] cmp_exp;
  logic [7:0] char_log[$];
  logic [7:0] cmd_log[$];
  logic [7:0] nf_log[$];
  int         cmd_pos[$];
  int         finish_cnt = 0, rkd_cnt = 0, nf_fin_cnt = 0, nf_rkd_cnt = 0;
  bit         hold_ack = 0;
  int         ack_cnt = 0, ack_nf = 0;
  logic [7:0] lcd_base [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sm_clk);
    #1;
  endtask

  // LCD writer stand-ins: acknowledge two cycles after a request.
  initial forever begin
    @(posedge sm_clk);
    #2;
    resp_fin = 1'b0;
    if (!reset) ack_cnt = 0;
    else if (start_lcd) ack_cnt = 2;
    else if (ack_cnt > 1) ack_cnt--;
    else if (ack_cnt == 1 && !hold_ack) begin
      resp_fin = 1'b1;
      ack_cnt  = 0;
    end
  end

  initial forever begin
    @(posedge sm_clk);
    #2;
    fin_nf = 1'b0;
    if (!reset) ack_nf = 0;
    else if (start_nf) ack_nf = 2;
    else if (ack_nf > 1) ack_nf--;
    else if (ack_nf == 1) begin
      fin_nf = 1'b1;
      ack_nf = 0;
    end
  end

  initial forever begin
    @(negedge sm_clk);
    if (reset) begin
      if (start_nf && !cmd_nf) nf_log.push_back(db_nf);
      if (finish_nf) nf_fin_cnt++;
      if (rkd_nf) nf_rkd_cnt++;
    end
  end

  // Compare process: every LCD request and completion is checked against the model.
  initial forever begin
    @(negedge sm_clk);
    if (!reset) begin
      m_q.delete();
      m_col = 0; m_line = 0;
      m_need_cmd = 0; m_perr = 0; m_ovf = 0; m_skip = 0;
      outst = 0; fin_due = 0;
    end else begin
      if (reset_kbd_data) rkd_cnt++;
      if (finish) finish_cnt++;
      if (fin_due) begin
        chk("finish_pulse", 32'(finish), 32'd1);
        fin_due = 0;
      end else begin
        chk("finish_unexpected", 32'(finish), 32'd0);
      end
      if (start_lcd) begin
        chk("start_while_busy", 32'(outst), 32'd0);
        if (m_need_cmd) begin
          cmp_exp = 8'h80 | lcd_base[(m_line + 1) % NL];
          chk("cmd_is_command", 32'(is_command), 32'd1);
          chk("cmd_db", 32'(db), 32'(cmp_exp));
          cmd_log.push_back(db);
          cmd_pos.push_back(char_log.size());
          cur_cmd = 1;
        end else if (m_q.size() == 0) begin
          chk("start_unexpected", 32'(start_lcd), 32'd0);
          cur_cmd = is_command;
        end else begin
          cmp_exp = m_q.pop_front();
          chk("char_is_command", 32'(is_command), 32'd0);
          chk("char_db", 32'(db), 32'(cmp_exp));
          char_log.push_back(db);
          cur_cmd = 0;
        end
        outst   = 1;
        cur_db  = db;
        cur_isc = is_command;
      end else if (outst) begin
        chk("db_stable", 32'(db), 32'(cur_db));
        chk("is_command_stable", 32'(is_command), 32'(cur_isc));
        if (lcd_fin) begin
          outst = 0;
          if (cur_cmd) begin
            m_need_cmd = 0;
            m_line     = (m_line + 1) % NL;
            fin_due    = 1;
          end else begin
            m_col++;
            if (m_col == LL) begin
              m_col      = 0;
              m_need_cmd = 1;
            end else begin
              fin_due = 1;
            end
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0);
    logic par;
    par = ~(^b) ^ bad_par;
    if (bad_par || bad_stop) m_perr = 1;
    else if (b == 8'hF0) m_skip = 1;
    else if (m_skip) m_skip = 0;
    else if (m_q.size() >= FD) m_ovf = 1;
    else m_q.push_back(b);
    kbd_data = {1'b0, b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], par, ~bad_stop};
    rkd_cnt  = 0;
    cycles(1);
    kbd_ready = 1'b1;
    cycles(3);
    kbd_ready = 1'b0;
    cycles(5);
    chk("reset_kbd_data_once", 32'(rkd_cnt), 32'd1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_q.size() != 0 || outst || m_need_cmd || fin_due) && t < 2000) begin
      cycles(1);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle: timeout with %0d queued", m_q.size());
    end
    cycles(3);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_db"}, 32'(db), 32'd0);
    chk({tag, "_is_command"}, 32'(is_command), 32'd0);
    chk({tag, "_start"}, 32'(start_lcd), 32'd0);
    chk({tag, "_finish"}, 32'(finish), 32'd0);
    chk({tag, "_reset_kbd_data"}, 32'(reset_kbd_data), 32'd0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    int n_before;
    // Reset with kbd_ready already high: no capture may follow release.
    kbd_ready = 1'b1;
    cycles(3);
    chk_reset_outputs("reset");
    rkd_cnt = 0;
    reset = 1'b1;
    cycles(4);
    chk("no_capture_after_reset", 32'(rkd_cnt), 32'd0);
    kbd_ready = 1'b0;
    cycles(2);

    // Single character 0x1C.
    finish_cnt = 0;
    send_frame(8'h1C);
    wait_idle();
    chk("single_count", 32'(char_log.size()), 32'd1);
    chk("single_byte", 32'(char_log[0]), 32'h1C);
    chk("single_finish", 32'(finish_cnt), 32'd1);

    // Break-code filtering on dut, pass-through on dut_nf.
    char_log.delete();
    nf_log.delete();
    nf_fin_cnt = 0;
    nf_rkd_cnt = 0;
    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    send_frame(8'h32);
    wait_idle();
    cycles(10);
    chk("filter_count", 32'(char_log.size()), 32'd2);
    chk("filter_b0", 32'(char_log[0]), 32'h1C);
    chk("filter_b1", 32'(char_log[1]), 32'h32);
    chk("nofilter_count", 32'(nf_log.size()), 32'd4);
    chk("nofilter_b1", 32'(nf_log[1]), 32'hF0);
    chk("nofilter_b3", 32'(nf_log[3]), 32'h32);
    chk("nofilter_finish", 32'(nf_fin_cnt), 32'd4);
    chk("nofilter_rkd", 32'(nf_rkd_cnt), 32'd4);

    // Bad parity, then (after reset) bad stop bit.
    char_log.delete();
    send_frame(8'h33, 1'b1, 1'b0);
    cycles(10);
    chk("bad_parity_err", 32'(parity_err), 32'd1);
    chk("bad_parity_model", 32'(parity_err), 32'(m_perr));
    chk("bad_parity_nf", 32'(perr_nf), 32'd1);
    chk("bad_parity_nowrite", 32'(char_log.size()), 32'd0);
    chk("bad_parity_ovf", 32'(overflow), 32'd0);
    do_reset();
    chk("perr_cleared", 32'(parity_err), 32'd0);
    send_frame(8'h33, 1'b0, 1'b1);
    cycles(10);
    chk("bad_stop_err", 32'(parity_err), 32'd1);
    chk("bad_stop_nowrite", 32'(char_log.size()), 32'd0);

    // Finished strobe while idle is ignored.
    finish_cnt = 0;
    spur_fin = 1'b1;
    cycles(2);
    spur_fin = 1'b0;
    cycles(4);
    chk("spurious_fin_finish", 32'(finish_cnt), 32'd0);
    chk("spurious_fin_fifo", 32'(fifo_count), 32'd0);

    // Overflow: six frames while the LCD writer never finishes.
    hold_ack = 1;
    finish_cnt = 0;
    for (int i = 0; i < 6; i++) send_frame(8'(8'h11 + i));
    chk("ovf_fifo_count", 32'(fifo_count), 32'd4);
    chk("ovf_fifo_model", 32'(fifo_count), 32'(m_q.size()));
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_flag_model", 32'(overflow), 32'(m_ovf));
    chk("ovf_in_progress", 32'(db), 32'h11);
    chk("ovf_one_started", 32'(char_log.size()), 32'd1);
    hold_ack = 0;
    wait_idle();
    chk("ovf_written", 32'(char_log.size()), 32'd5);
    chk("ovf_last", 32'(char_log[4]), 32'h15);
    chk("ovf_finish", 32'(finish_cnt), 32'd5);
    chk("ovf_nf_clear", 32'(ovf_nf), 32'd0);
    chk("ovf_nf_empty", 32'(cnt_nf), 32'd0);

    // Line wrapping over 33 characters.
    do_reset();
    char_log.delete();
    cmd_log.delete();
    cmd_pos.delete();
    for (int i = 0; i < 33; i++) begin
      send_frame(8'(65 + i % 26));
      wait_idle();
    end
    chk("wrap_chars", 32'(char_log.size()), 32'd33);
    chk("wrap_cmds", 32'(cmd_log.size()), 32'd2);
    chk("wrap_cmd0", 32'(cmd_log[0]), 32'hC0);
    chk("wrap_cmd1", 32'(cmd_log[1]), 32'h80);
    chk("wrap_pos0", 32'(cmd_pos[0]), 32'd16);
    chk("wrap_pos1", 32'(cmd_pos[1]), 32'd32);
    chk("wrap_col", 32'(m_col), 32'd1);
    chk("wrap_line", 32'(m_line), 32'd0);

    // Reset during D_WAIT abandons the handshake.
    hold_ack = 1;
    finish_cnt = 0;
    send_frame(8'h55);
    send_frame(8'h66);
    chk("midreset_busy", 32'(outst), 32'd1);
    chk("midreset_fifo", 32'(fifo_count), 32'd1);
    n_before = char_log.size();
    reset = 1'b0;
    cycles(1);
    chk_reset_outputs("midreset");
    reset = 1'b1;
    hold_ack = 0;
    cycles(20);
    chk("midreset_no_finish", 32'(finish_cnt), 32'd0);
    chk("midreset_no_write", 32'(char_log.size()), 32'(n_before));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
